data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 33 +++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/data_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access-size codes,
// FSM state type, wait-counter width and a misalignment helper.
// No ports; imported by data_mem_responder and dmem_lane_align.
package data_mem_responder_pkg;

    // Wait-counter width; LATENCY is limited to 0..15.
    localparam int LAT_W = 4;

    // req_size encodings.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // A half must sit on an even byte and a word on a 4-byte boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic m;
        m = 1'b0;
        case (size)
            SZ_HALF: m = offset[0];
            SZ_WORD: m = (offset != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purpose: byte-lane steering between a 32-bit storage word and a sized access.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle from its inputs.
// Ports: size/offset select the lanes; wdata/wmask/wdata_sh form the store;
//        rword/is_unsigned produce the extended load value rdata.
// Half accesses ignore offset[0] and word accesses ignore offset entirely, so an
// unaligned request is implicitly forced down to its natural boundary.
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic        is_unsigned,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wmask    = 4'b0000;
        wdata_sh = 32'h0;
        rdata    = 32'h0;
        ld_byte  = rword[{offset, 3'b000} +: 8];
        ld_half  = offset[1] ? rword[31:16] : rword[15:0];
        case (size)
            SZ_BYTE: begin
                // Data is replicated on every lane; the mask picks the live one.
                wmask    = 4'b0001 << offset;
                wdata_sh = {4{wdata[7:0]}};
                rdata    = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                wmask    = offset[1] ? 4'b1100 : 4'b0011;
                wdata_sh = {2{wdata[15:0]}};
                rdata    = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                // SZ_WORD, and SZ_ILL when it is not rejected upstream.
                wmask    = 4'b1111;
                wdata_sh = wdata;
                rdata    = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Purpose: single-outstanding load/store responder over a DEPTH_WORDS x 32 store.
// Latency: response valid LATENCY+1 cycles after the accept edge; accept spacing >= LATENCY+2.
// Backpressure: one request in flight; req_ready low until the response is taken (resp_ready).
// Ports: clk, rst (async active-low); req_valid/req_ready/req_we/req_addr/req_wdata/
//        req_size/req_unsigned request channel; resp_valid/resp_ready/resp_rdata/resp_err.
// Option: define DMEM_ERR_CHECK_EN to reject misaligned, size-11 and out-of-range
//         requests with resp_err; otherwise the index wraps and the access is forced aligned.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    state_t           state, state_nxt;
    logic [LAT_W-1:0] cnt, cnt_nxt;
    logic             accept;
    logic             acc_fire;

    // Request captured at accept.
    logic        r_we, r_uns;
    logic [31:0] r_addr, r_wdata;
    logic [1:0]  r_size;

    // Fields seen by the access: live inputs when the access happens on the
    // accept edge itself (LATENCY = 0), captured copies otherwise.
    logic        a_we, a_uns;
    logic [31:0] a_addr, a_wdata;
    logic [1:0]  a_size;
    logic [IDX_W-1:0] a_idx;
    logic        acc_err;
    logic        unused_ok;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rword;
    logic [3:0]  wmask;
    logic [31:0] wdata_sh;
    logic [31:0] ld_data;

    // Gated by rst so nothing can be accepted (and stored, at LATENCY = 0) during reset.
    assign req_ready  = (state == IDLE) & rst;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid & req_ready;

    always_comb begin
        if (state == IDLE) begin
            a_we    = req_we;
            a_uns   = req_unsigned;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_size  = req_size;
        end else begin
            a_we    = r_we;
            a_uns   = r_uns;
            a_addr  = r_addr;
            a_wdata = r_wdata;
            a_size  = r_size;
        end
    end

    // Out-of-range upper bits are simply dropped here, giving modulo wrap.
    assign a_idx = a_addr[IDX_W+1:2];
    assign rword = mem[a_idx];

`ifdef DMEM_ERR_CHECK_EN
    assign acc_err   = (a_size == SZ_ILL)
                     | misaligned(a_size, a_addr[1:0])
                     | (|a_addr[31:IDX_W+2]);
    assign unused_ok = 1'b0;
`else
    assign acc_err   = 1'b0;
    assign unused_ok = ^a_addr[31:IDX_W+2];
`endif

    dmem_lane_align u_align (
        .size        (a_size),
        .offset      (a_addr[1:0]),
        .wdata       (a_wdata),
        .is_unsigned (a_uns),
        .rword       (rword),
        .wmask       (wmask),
        .wdata_sh    (wdata_sh),
        .rdata       (ld_data)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        acc_fire  = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = LAT_LOAD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    acc_fire  = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_size     <= SZ_BYTE;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
            end
            if (acc_fire) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || a_we) ? 32'h0 : ld_data;
            end
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (acc_fire && rst && a_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[a_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 instance driven from a vector table,
// plus a LATENCY=0 instance for back-to-back spacing, and hand sequences for
// backpressure and reset during WAIT/RESP.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // LATENCY = 2 instance
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    // LATENCY = 0 instance
    logic        req_valid0, req_ready0, req_we0, req_unsigned0;
    logic [31:0] req_addr0, req_wdata0;
    logic [1:0]  req_size0;
    logic        resp_valid0, resp_ready0, resp_err0;
    logic [31:0] resp_rdata0;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_size(req_size0),
        .req_unsigned(req_unsigned0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input string n, input logic we, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] s, input logic u,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = n; v.we = we; v.addr = a; v.wdata = d; v.size = s; v.uns = u;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // One request on the LATENCY=2 instance; req_* are scrambled right after
    // the accept edge so a design that keeps sampling them would misbehave.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic rr,
                        output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns; resp_ready = rr;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF;
        req_wdata = ~wdata; req_size = SZ_BYTE; req_unsigned = ~uns;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    initial begin
        logic [31:0] rd, held_rd;
        logic        er, held_er;
        int          lat, acc0;

        rst = 1'b0;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0;
        req_unsigned = 0; resp_ready = 1;
        req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_size0 = 0;
        req_unsigned0 = 0; resp_ready0 = 1;

        // Reset state
        #12;
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", resp_err, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1'b1);

        // LATENCY = 0: store, then hold a load request and watch the spacing
        req_valid0 = 1; req_we0 = 1; req_addr0 = 32'h8; req_wdata0 = 32'hA5A5_0001;
        req_size0 = SZ_WORD;
        @(posedge clk); #1;
        req_valid0 = 0;
        chk("l0_store_valid", resp_valid0, 1'b1);
        chk("l0_store_rdata", resp_rdata0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid0 = 1; req_we0 = 0;
        acc0 = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("l0_ready_%0d", k), req_ready0, (k % 2) == 0);
            chk($sformatf("l0_valid_%0d", k), resp_valid0, (k % 2) == 1);
            if (resp_valid0) chk($sformatf("l0_rdata_%0d", k), resp_rdata0, 32'hA5A5_0001);
            if (req_valid0 && req_ready0) acc0++;
            @(negedge clk);
        end
        req_valid0 = 0;
        chk("l0_accepts", acc0, 4);

        // Table-driven vectors on the LATENCY = 2 instance
        vecs.push_back(mk("st_w0",     1, 32'h00, 32'hCAFE_F00D, SZ_WORD, 0, 32'h0, 0));
        vecs.push_back(mk("st_w10",    1, 32'h10, 32'hDEAD_BEEF, SZ_WORD, 0, 32'h0, 0));
        vecs.push_back(mk("ld_w10",    0, 32'h10, 32'h0,         SZ_WORD, 0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk("st_b13",    1, 32'h13, 32'h1234_5680, SZ_BYTE, 0, 32'h0, 0));
        vecs.push_back(mk("ld_bs13",   0, 32'h13, 32'h0,         SZ_BYTE, 0, 32'hFFFF_FF80, 0));
        vecs.push_back(mk("ld_bu13",   0, 32'h13, 32'h0,         SZ_BYTE, 1, 32'h0000_0080, 0));
        vecs.push_back(mk("ld_w10b",   0, 32'h10, 32'h0,         SZ_WORD, 0, 32'h80AD_BEEF, 0));
        vecs.push_back(mk("st_h22",    1, 32'h22, 32'hAAAA_1234, SZ_HALF, 0, 32'h0, 0));
        vecs.push_back(mk("st_h20",    1, 32'h20, 32'h5555_8001, SZ_HALF, 0, 32'h0, 0));
        vecs.push_back(mk("ld_w20",    0, 32'h20, 32'h0,         SZ_WORD, 0, 32'h1234_8001, 0));
        vecs.push_back(mk("ld_hs20",   0, 32'h20, 32'h0,         SZ_HALF, 0, 32'hFFFF_8001, 0));
        vecs.push_back(mk("ld_hu22",   0, 32'h22, 32'h0,         SZ_HALF, 1, 32'h0000_1234, 0));
        vecs.push_back(mk("ld_bs21",   0, 32'h21, 32'h0,         SZ_BYTE, 0, 32'hFFFF_FF80, 0));
        vecs.push_back(mk("ld_hu10",   0, 32'h10, 32'h0,         SZ_HALF, 1, 32'h0000_BEEF, 0));
        vecs.push_back(mk("ld_hs12",   0, 32'h12, 32'h0,         SZ_HALF, 0, 32'hFFFF_80AD, 0));
        vecs.push_back(mk("st_w40",    1, 32'h40, 32'h0BAD_F00D, SZ_WORD, 0, 32'h0, 0));
`ifdef DMEM_ERR_CHECK_EN
        vecs.push_back(mk("err_h21",   0, 32'h21,  32'h0,         SZ_HALF, 0, 32'h0, 1));
        vecs.push_back(mk("err_w400",  1, 32'h400, 32'h1111_1111, SZ_WORD, 0, 32'h0, 1));
        vecs.push_back(mk("ld_w0",     0, 32'h00,  32'h0,         SZ_WORD, 0, 32'hCAFE_F00D, 0));
        vecs.push_back(mk("err_sz3",   0, 32'h10,  32'h0,         SZ_ILL,  0, 32'h0, 1));
        vecs.push_back(mk("err_w12",   0, 32'h12,  32'h0,         SZ_WORD, 0, 32'h0, 1));
`else
        vecs.push_back(mk("aln_h21",   0, 32'h21,  32'h0,         SZ_HALF, 0, 32'hFFFF_8001, 0));
        vecs.push_back(mk("wrap_w400", 1, 32'h400, 32'h1111_1111, SZ_WORD, 0, 32'h0, 0));
        vecs.push_back(mk("ld_w0",     0, 32'h00,  32'h0,         SZ_WORD, 0, 32'h1111_1111, 0));
        vecs.push_back(mk("sz3_w10",   0, 32'h10,  32'h0,         SZ_ILL,  0, 32'h80AD_BEEF, 0));
        vecs.push_back(mk("aln_w12",   0, 32'h12,  32'h0,         SZ_WORD, 0, 32'h80AD_BEEF, 0));
`endif
        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, 1'b1,
                 rd, er, lat);
            chk({vecs[i].name, "_lat"}, lat, 3);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"}, er, vecs[i].exp_err);
            @(posedge clk); #1;
        end

        // Backpressure: hold the response for five cycles
        xact(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 1'b0, rd, er, lat);
        chk("bp_lat", lat, 3);
        chk("bp_rdata", rd, 32'h80AD_BEEF);
        held_rd = resp_rdata;
        held_er = resp_err;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_%0d", k), resp_valid, 1'b1);
            chk($sformatf("bp_rdata_%0d", k), resp_rdata, held_rd);
            chk($sformatf("bp_err_%0d", k), resp_err, held_er);
            chk($sformatf("bp_ready_%0d", k), req_ready, 1'b0);
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", resp_valid, 1'b0);
        chk("bp_release_ready", req_ready, 1'b1);

        // Reset during WAIT of a store must abort it
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'h1234_5678;
        req_size = SZ_WORD; req_unsigned = 0; resp_ready = 1;
        @(posedge clk); #1;
        req_valid = 0;
        chk("wait_no_valid", resp_valid, 1'b0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("wrst_valid", resp_valid, 1'b0);
        chk("wrst_rdata", resp_rdata, 32'h0);
        chk("wrst_err", resp_err, 1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("wrst_no_resp", resp_valid, 1'b0);
        xact(1'b0, 32'h40, 32'h0, SZ_WORD, 1'b0, 1'b1, rd, er, lat);
        chk("wrst_keep_lat", lat, 3);
        chk("wrst_keep_rdata", rd, 32'h0BAD_F00D);
        @(posedge clk); #1;

        // Reset during RESP drops the response
        xact(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, 1'b0, rd, er, lat);
        chk("rrst_pre_valid", resp_valid, 1'b1);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rrst_valid", resp_valid, 1'b0);
        chk("rrst_rdata", resp_rdata, 32'h0);
        @(negedge clk); rst = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        chk("rrst_ready", req_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
